// File: rtl/turn_ctl.sv
// Turn sequencer for the castle-vs-dragon duel. It alternates turn ownership, pulses next_turn
// to the wind generator, waits for the wind to settle, runs the aim window and tracks the shot.
module turn_ctl #(
  parameter int TURN_MS    = 15000,
  parameter int SETTLE_CYC = 3,
  parameter int TURN_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ms_tick,
  input  logic              game_start,
  input  logic              is_host,
  input  logic              fire_local,
  input  logic              fire_remote,
  input  logic              shot_done,
  input  logic              hit,
  output logic              next_turn,
  output logic              wind_valid,
  output logic              local_turn,
  output logic              fire_en,
  output logic [TURN_W-1:0] turn_cnt,
  output logic              timeout,
  output logic              game_over,
  output logic              winner_local
);

  // Counters only need to reach their last value (LIMIT-1), never the limit itself.
  localparam int MS_W  = (TURN_MS > 1) ? $clog2(TURN_MS) : 1;
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(TURN_MS - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEXT,
    S_SETTLE,
    S_AIM,
    S_FLIGHT,
    S_OVER
  } state_t;

  state_t state_reg, state_next;

  logic [MS_W-1:0]   ms_cnt_reg, ms_cnt_next;
  logic [SET_W-1:0]  settle_cnt_reg, settle_cnt_next;
  logic [TURN_W-1:0] turn_cnt_reg, turn_cnt_next;
  logic              next_turn_reg, next_turn_next;
  logic              wind_valid_reg, wind_valid_next;
  logic              local_turn_reg, local_turn_next;
  logic              fire_en_reg, fire_en_next;
  logic              timeout_reg, timeout_next;
  logic              game_over_reg, game_over_next;
  logic              winner_local_reg, winner_local_next;

  logic              owner_fire;
  logic              aim_expired;
  logic [TURN_W-1:0] turn_cnt_inc;

  assign owner_fire   = local_turn_reg ? fire_local : fire_remote;
  assign turn_cnt_inc = (turn_cnt_reg == '1) ? turn_cnt_reg : turn_cnt_reg + TURN_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    ms_cnt_next       = ms_cnt_reg;
    settle_cnt_next   = settle_cnt_reg;
    turn_cnt_next     = turn_cnt_reg;
    local_turn_next   = local_turn_reg;
    wind_valid_next   = wind_valid_reg;
    timeout_next      = timeout_reg;
    game_over_next    = game_over_reg;
    winner_local_next = winner_local_reg;
    next_turn_next    = 1'b0;
    fire_en_next      = 1'b0;
    aim_expired       = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (game_start) begin
          local_turn_next = is_host;
          state_next      = S_NEXT;
        end
      end

      S_NEXT: begin
        state_next = S_SETTLE;
      end

      S_SETTLE: begin
        if (settle_cnt_reg == SET_LAST) begin
          wind_valid_next = 1'b1;
          state_next      = S_AIM;
        end else begin
          settle_cnt_next = settle_cnt_reg + SET_W'(1);
        end
      end

      S_AIM: begin
        // A fire landing on the final tick still counts as a shot.
        if (owner_fire) begin
          fire_en_next = 1'b1;
          state_next   = S_FLIGHT;
        end else if (ms_tick) begin
          if (ms_cnt_reg == MS_LAST) begin
            aim_expired     = 1'b1;
            turn_cnt_next   = turn_cnt_inc;
            local_turn_next = ~local_turn_reg;
            state_next      = S_NEXT;
          end else begin
            ms_cnt_next = ms_cnt_reg + MS_W'(1);
          end
        end
      end

      S_FLIGHT: begin
        if (shot_done) begin
          turn_cnt_next = turn_cnt_inc;
          if (hit) begin
            game_over_next    = 1'b1;
            winner_local_next = local_turn_reg;
            state_next        = S_OVER;
          end else begin
            local_turn_next = ~local_turn_reg;
            state_next      = S_NEXT;
          end
        end
      end

      S_OVER: begin
        if (game_start) begin
          game_over_next    = 1'b0;
          turn_cnt_next     = '0;
          winner_local_next = 1'b0;
          local_turn_next   = is_host;
          state_next        = S_NEXT;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Turn-start side effects are keyed on entry so next_turn is a clean registered pulse.
    if (state_next == S_NEXT) begin
      next_turn_next  = 1'b1;
      wind_valid_next = 1'b0;
      timeout_next    = aim_expired;
    end
    if ((state_next == S_SETTLE) && (state_reg != S_SETTLE)) begin
      settle_cnt_next = '0;
    end
    if ((state_next == S_AIM) && (state_reg != S_AIM)) begin
      ms_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ms_cnt_reg       <= '0;
      settle_cnt_reg   <= '0;
      turn_cnt_reg     <= '0;
      next_turn_reg    <= 1'b0;
      wind_valid_reg   <= 1'b0;
      local_turn_reg   <= 1'b0;
      fire_en_reg      <= 1'b0;
      timeout_reg      <= 1'b0;
      game_over_reg    <= 1'b0;
      winner_local_reg <= 1'b0;
    end else begin
      ms_cnt_reg       <= ms_cnt_next;
      settle_cnt_reg   <= settle_cnt_next;
      turn_cnt_reg     <= turn_cnt_next;
      next_turn_reg    <= next_turn_next;
      wind_valid_reg   <= wind_valid_next;
      local_turn_reg   <= local_turn_next;
      fire_en_reg      <= fire_en_next;
      timeout_reg      <= timeout_next;
      game_over_reg    <= game_over_next;
      winner_local_reg <= winner_local_next;
    end
  end

  assign next_turn    = next_turn_reg;
  assign wind_valid   = wind_valid_reg;
  assign local_turn   = local_turn_reg;
  assign fire_en      = fire_en_reg;
  assign turn_cnt     = turn_cnt_reg;
  assign timeout      = timeout_reg;
  assign game_over    = game_over_reg;
  assign winner_local = winner_local_reg;

  // The wind generator edge-detects next_turn, so it must never stay high two cycles running.
  a_next_turn_single: assert property (@(posedge clk) disable iff (rst) next_turn |=> !next_turn);
  a_fire_en_single:   assert property (@(posedge clk) disable iff (rst) fire_en |=> !fire_en);

endmodule

// File: tb/tb_turn_ctl.sv
// Bench for turn_ctl: a directed vector table, hand-written reset sequences, and a randomized
// run checked against a turn-level reference model.
module tb_turn_ctl;
  localparam int TM   = 5;
  localparam int SC   = 3;
  localparam int TW   = 4;
  localparam int MAXC = (1 << TW) - 1;

  logic clk = 1'b0;
  logic rst, ms_tick, game_start, is_host, fire_local, fire_remote, shot_done, hit;
  logic next_turn, wind_valid, local_turn, fire_en, timeout, game_over, winner_local;
  logic [TW-1:0] turn_cnt;
  logic [TW+6:0] act;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  turn_ctl #(.TURN_MS(TM), .SETTLE_CYC(SC), .TURN_W(TW)) dut (
    .clk(clk), .rst(rst), .ms_tick(ms_tick), .game_start(game_start), .is_host(is_host),
    .fire_local(fire_local), .fire_remote(fire_remote), .shot_done(shot_done), .hit(hit),
    .next_turn(next_turn), .wind_valid(wind_valid), .local_turn(local_turn), .fire_en(fire_en),
    .turn_cnt(turn_cnt), .timeout(timeout), .game_over(game_over), .winner_local(winner_local)
  );

  assign act = {next_turn, wind_valid, local_turn, fire_en, turn_cnt, timeout, game_over, winner_local};

  function automatic logic [TW+6:0] pack(input bit nt, wv, lt, fe, input int cnt, input bit to, go, win);
    return {nt, wv, lt, fe, TW'(cnt), to, go, win};
  endfunction

  task automatic check(input string name, input logic [TW+6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {nt,wv,lt,fe,cnt,to,go,win}=%b want %b", name, act, exp);
    end
  endtask

  task automatic drive(input bit gs, host, fl, fr, ms, sd, h);
    game_start = gs; is_host = host; fire_local = fl; fire_remote = fr;
    ms_tick = ms; shot_done = sd; hit = h;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: inputs applied before an edge, outputs checked just after it.
  typedef struct {
    bit gs, host, fl, fr, ms, sd, h;
    bit nt, wv, lt, fe;
    int cnt;
    bit to, go, win;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit gs, host, fl, fr, ms, sd, h, nt, wv, lt, fe,
                     input int cnt, input bit to, go, win);
    vec_t v;
    v.gs = gs; v.host = host; v.fl = fl; v.fr = fr; v.ms = ms; v.sd = sd; v.h = h;
    v.nt = nt; v.wv = wv; v.lt = lt; v.fe = fe; v.cnt = cnt; v.to = to; v.go = go; v.win = win;
    tbl.push_back(v);
  endtask

  // Reference model: a turn is "age" cycles old; the wind is valid once age reaches SC+1,
  // after which the aim window runs until a shot or TM ms ticks.
  bit m_in_turn, m_fly, m_over;
  int m_age, m_ticks;
  bit e_nt, e_wv, e_lt, e_fe, e_to, e_go, e_win;
  int e_cnt;

  task automatic begin_turn(input bit t);
    m_in_turn = 1; m_fly = 0; m_age = 0;
    e_nt = 1; e_wv = 0; e_to = t;
  endtask

  task automatic model_edge(input bit r, gs, host, fl, fr, ms, sd, h);
    if (r) begin
      m_in_turn = 0; m_fly = 0; m_over = 0; m_age = 0; m_ticks = 0;
      e_nt = 0; e_wv = 0; e_lt = 0; e_fe = 0; e_to = 0; e_go = 0; e_win = 0; e_cnt = 0;
      return;
    end
    e_nt = 0;
    e_fe = 0;
    if (!m_in_turn) begin
      if (gs) begin
        if (m_over) begin
          e_go = 0; e_cnt = 0; e_win = 0; m_over = 0;
        end
        e_lt = host;
        begin_turn(0);
      end
    end else if (m_fly) begin
      if (sd) begin
        e_cnt = (e_cnt < MAXC) ? e_cnt + 1 : MAXC;
        m_fly = 0;
        if (h) begin
          e_go = 1; e_win = e_lt; m_over = 1; m_in_turn = 0;
        end else begin
          e_lt = !e_lt;
          begin_turn(0);
        end
      end
    end else if (m_age <= SC) begin
      m_age++;
      if (m_age == SC + 1) begin
        e_wv = 1; m_ticks = 0;
      end
    end else begin
      if ((e_lt && fl) || (!e_lt && fr)) begin
        e_fe = 1; m_fly = 1;
      end else if (ms) begin
        m_ticks++;
        if (m_ticks >= TM) begin
          e_cnt = (e_cnt < MAXC) ? e_cnt + 1 : MAXC;
          e_lt = !e_lt;
          begin_turn(1);
        end
      end
    end
  endtask

  initial begin
    #2ms;
    n_bad++;
    $display("FAIL watchdog: got no finish within time limit want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    bit r_rst, r_gs, r_host, r_fl, r_fr, r_ms, r_sd, r_h;
    bit go_prev;

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    check("reset", '0);
    rst = 1'b0;
    step();
    check("idle_after_reset", '0);

    //  gs h fl fr ms sd hit | nt wv lt fe cnt to go win
    add(1, 1, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0, 0);
    repeat (3) add(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0,   0, 1, 1, 0, 0, 0, 0, 0);
    repeat (3) add(0, 0, 0, 0, 1, 0, 0,   0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0,   0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 1, 0, 0, 0);
    repeat (3) add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0,   0, 1, 0, 0, 1, 0, 0, 0);
    repeat (3) add(0, 0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   1, 0, 1, 0, 2, 1, 0, 0);
    repeat (3) add(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 2, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0,   0, 1, 1, 1, 2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 3, 0, 0, 0);
    repeat (3) add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 3, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0,   0, 1, 0, 1, 3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1,   0, 1, 0, 0, 4, 0, 1, 0);
    add(0, 0, 1, 1, 1, 1, 1,   0, 1, 0, 0, 4, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].gs, tbl[i].host, tbl[i].fl, tbl[i].fr, tbl[i].ms, tbl[i].sd, tbl[i].h);
      step();
      check($sformatf("vec%0d", i), pack(tbl[i].nt, tbl[i].wv, tbl[i].lt, tbl[i].fe,
                                         tbl[i].cnt, tbl[i].to, tbl[i].go, tbl[i].win));
      $display("vec %0d: nt=%b wv=%b lt=%b fe=%b cnt=%0d to=%b go=%b win=%b", i,
               next_turn, wind_valid, local_turn, fire_en, turn_cnt, timeout, game_over, winner_local);
    end

    // Asynchronous reset while aiming: outputs drop without waiting for a clock edge.
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("rst_async_aim", '0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, k[0], !k[0], 1, 1, 1);
      step();
      check($sformatf("idle_hold%0d", k), '0);
      $display("idle %0d: outputs=%b", k, act);
    end

    drive(1, 1, 0, 0, 0, 0, 0);
    step();
    check("start_host", pack(1, 0, 1, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("settle%0d", k), pack(0, k == 4, 1, 0, 0, 0, 0, 0));
      $display("settle %0d: nt=%b wv=%b", k, next_turn, wind_valid);
    end
    drive(0, 0, 1, 0, 0, 0, 0);
    step();
    check("fire_local", pack(0, 1, 1, 1, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 1, 0);
    step();
    check("miss", pack(1, 0, 0, 0, 1, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    check("settle_again", pack(0, 0, 0, 0, 1, 0, 0, 0));
    rst = 1'b1;
    #1;
    check("rst_async_settle", '0);
    step();
    check("rst_held", '0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 1, 1, 0, 0);
      step();
      check($sformatf("idle_after_rst%0d", k), '0);
      $display("idle_after_rst %0d: outputs=%b", k, act);
    end

    // Randomized run against the reference model.
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    model_edge(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b0;
    go_prev = 0;
    for (int c = 0; c < 4000; c++) begin
      r_rst  = ($urandom_range(0, 999) < 3);
      r_gs   = ($urandom_range(0, 99) < 4);
      r_host = $urandom_range(0, 1);
      r_fl   = ($urandom_range(0, 99) < 8);
      r_fr   = ($urandom_range(0, 99) < 8);
      r_ms   = ($urandom_range(0, 99) < 30);
      r_sd   = ($urandom_range(0, 99) < 20);
      r_h    = ($urandom_range(0, 99) < 6);
      rst = r_rst;
      drive(r_gs, r_host, r_fl, r_fr, r_ms, r_sd, r_h);
      @(posedge clk);
      model_edge(r_rst, r_gs, r_host, r_fl, r_fr, r_ms, r_sd, r_h);
      #1;
      check($sformatf("rand%0d", c), pack(e_nt, e_wv, e_lt, e_fe, e_cnt, e_to, e_go, e_win));
      if (e_nt)
        $display("rand %0d: turn start lt=%b cnt=%0d to=%b", c, e_lt, e_cnt, e_to);
      if (e_go && !go_prev)
        $display("rand %0d: game over winner_local=%b cnt=%0d", c, e_win, e_cnt);
      go_prev = e_go;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
